// File: rtl/rs_issue_queue.sv
`default_nettype none
// ============================================================================
//  Module   : rs_issue_queue
//  Purpose  : Reservation-station issue queue for one execution class.
//             Ordered, collapsing queue (slot 0 = oldest). Accepts renamed
//             micro-ops from dispatch, wakes sources on physical-tag
//             broadcasts and offers the oldest fully-ready entry to Issue.
//  Ports    : clk/rst (sync, active-low)   flush_i
//             disp_*_i / disp_ready_o       dispatch handshake + entry fields
//             wake_valid_i / wake_tag_i     writeback tag broadcasts
//             issue_valid_o / issue_ready_i issue handshake
//             issue_*_o                     selected entry fields
//             occupancy_o                   number of valid entries
//  Revision : 1.0  initial release
// ============================================================================
module rs_issue_queue #(
    parameter int DEPTH      = 8,
    parameter int PHY_WIDTH  = 6,
    parameter int ROB_WIDTH  = 5,
    parameter int PAYLOAD_W  = 64,
    parameter int WAKE_PORTS = 2,
    localparam int IW        = $clog2(DEPTH),
    localparam int CW        = IW + 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush_i,
    input  logic                            disp_valid_i,
    output logic                            disp_ready_o,
    input  logic [ROB_WIDTH-1:0]            disp_rob_id_i,
    input  logic [PHY_WIDTH-1:0]            disp_prd_i,
    input  logic [PHY_WIDTH-1:0]            disp_prs1_i,
    input  logic [PHY_WIDTH-1:0]            disp_prs2_i,
    input  logic                            disp_rs1_rdy_i,
    input  logic                            disp_rs2_rdy_i,
    input  logic [PAYLOAD_W-1:0]            disp_payload_i,
    input  logic [WAKE_PORTS-1:0]           wake_valid_i,
    input  logic [WAKE_PORTS*PHY_WIDTH-1:0] wake_tag_i,
    output logic                            issue_valid_o,
    input  logic                            issue_ready_i,
    output logic [ROB_WIDTH-1:0]            issue_rob_id_o,
    output logic [PHY_WIDTH-1:0]            issue_prd_o,
    output logic [PHY_WIDTH-1:0]            issue_prs1_o,
    output logic [PHY_WIDTH-1:0]            issue_prs2_o,
    output logic [PAYLOAD_W-1:0]            issue_payload_o,
    output logic [CW-1:0]                   occupancy_o
);

    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

    // Slot state
    logic [DEPTH-1:0]     valid_q, valid_d;
    logic [DEPTH-1:0]     rdy1_q, rdy1_d;
    logic [DEPTH-1:0]     rdy2_q, rdy2_d;
    logic [ROB_WIDTH-1:0] rob_q  [DEPTH];
    logic [ROB_WIDTH-1:0] rob_d  [DEPTH];
    logic [PHY_WIDTH-1:0] prd_q  [DEPTH];
    logic [PHY_WIDTH-1:0] prd_d  [DEPTH];
    logic [PHY_WIDTH-1:0] prs1_q [DEPTH];
    logic [PHY_WIDTH-1:0] prs1_d [DEPTH];
    logic [PHY_WIDTH-1:0] prs2_q [DEPTH];
    logic [PHY_WIDTH-1:0] prs2_d [DEPTH];
    logic [PAYLOAD_W-1:0] pay_q  [DEPTH];
    logic [PAYLOAD_W-1:0] pay_d  [DEPTH];
    logic [CW-1:0]        count_q, count_d;

    logic [DEPTH-1:0]     w_wk1, w_wk2;
    logic                 w_dwk1, w_dwk2;
    logic [IW-1:0]        w_sel;
    logic                 w_found;
    logic                 w_issue_fire, w_disp_fire;
    logic [CW-1:0]        w_widx;

    // Tag broadcast match against every stored source and the incoming op
    always_comb begin
        w_wk1  = '0;
        w_wk2  = '0;
        w_dwk1 = 1'b0;
        w_dwk2 = 1'b0;
        for (int p = 0; p < WAKE_PORTS; p++) begin
            if (wake_valid_i[p]) begin
                for (int s = 0; s < DEPTH; s++) begin
                    if (wake_tag_i[p*PHY_WIDTH +: PHY_WIDTH] == prs1_q[s]) w_wk1[s] = 1'b1;
                    if (wake_tag_i[p*PHY_WIDTH +: PHY_WIDTH] == prs2_q[s]) w_wk2[s] = 1'b1;
                end
                if (wake_tag_i[p*PHY_WIDTH +: PHY_WIDTH] == disp_prs1_i) w_dwk1 = 1'b1;
                if (wake_tag_i[p*PHY_WIDTH +: PHY_WIDTH] == disp_prs2_i) w_dwk2 = 1'b1;
            end
        end
    end

    // Oldest-ready select: scan downward so the lowest index wins
    always_comb begin
        w_sel   = '0;
        w_found = 1'b0;
        for (int s = DEPTH - 1; s >= 0; s--) begin
            if (valid_q[s] && rdy1_q[s] && rdy2_q[s]) begin
                w_sel   = IW'(s);
                w_found = 1'b1;
            end
        end
    end

    assign issue_valid_o   = w_found && !flush_i;
    assign issue_rob_id_o  = rob_q[w_sel];
    assign issue_prd_o     = prd_q[w_sel];
    assign issue_prs1_o    = prs1_q[w_sel];
    assign issue_prs2_o    = prs2_q[w_sel];
    assign issue_payload_o = pay_q[w_sel];
    assign disp_ready_o    = (count_q < C_DEPTH) && !flush_i;
    assign occupancy_o     = count_q;

    assign w_issue_fire = issue_valid_o && issue_ready_i;
    assign w_disp_fire  = disp_valid_i && disp_ready_o;
    // Dispatch lands just past the last valid entry after the collapse
    assign w_widx       = count_q - CW'(w_issue_fire);

    // Next state: collapse above the issued slot, apply wakes, then dispatch
    always_comb begin
        int src;
        for (int s = 0; s < DEPTH; s++) begin
            src = s;
            if (w_issue_fire && (IW'(s) >= w_sel) && (s < DEPTH - 1)) src = s + 1;
            valid_d[s] = valid_q[src];
            rdy1_d[s]  = rdy1_q[src] | w_wk1[src];
            rdy2_d[s]  = rdy2_q[src] | w_wk2[src];
            rob_d[s]   = rob_q[src];
            prd_d[s]   = prd_q[src];
            prs1_d[s]  = prs1_q[src];
            prs2_d[s]  = prs2_q[src];
            pay_d[s]   = pay_q[src];
            // Top slot has nothing above it to shift in
            if (w_issue_fire && (IW'(s) >= w_sel) && (s == DEPTH - 1)) valid_d[s] = 1'b0;
            if (w_disp_fire && (w_widx == CW'(s))) begin
                valid_d[s] = 1'b1;
                rdy1_d[s]  = disp_rs1_rdy_i | (disp_prs1_i == '0) | w_dwk1;
                rdy2_d[s]  = disp_rs2_rdy_i | (disp_prs2_i == '0) | w_dwk2;
                rob_d[s]   = disp_rob_id_i;
                prd_d[s]   = disp_prd_i;
                prs1_d[s]  = disp_prs1_i;
                prs2_d[s]  = disp_prs2_i;
                pay_d[s]   = disp_payload_i;
            end
        end
        count_d = count_q + CW'(w_disp_fire) - CW'(w_issue_fire);
        if (flush_i) begin
            valid_d = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    // Payload fields need no reset: they are qualified by valid_q
    always_ff @(posedge clk) begin
        rdy1_q <= rdy1_d;
        rdy2_q <= rdy2_d;
        rob_q  <= rob_d;
        prd_q  <= prd_d;
        prs1_q <= prs1_d;
        prs2_q <= prs2_d;
        pay_q  <= pay_d;
    end

    // Structural invariants
    logic [CW-1:0] w_pop;
    logic          w_contig;
    always_comb begin
        w_pop    = '0;
        w_contig = 1'b1;
        for (int s = 0; s < DEPTH; s++) w_pop = w_pop + CW'(valid_q[s]);
        for (int s = 1; s < DEPTH; s++) begin
            if (valid_q[s] && !valid_q[s-1]) w_contig = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            assert (count_q <= C_DEPTH);
            assert (w_pop == count_q);
            assert (w_contig);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rs_issue_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rs_issue_queue
//  Purpose  : Directed self-checking bench for rs_issue_queue.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rs_issue_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        disp_valid_i;
    logic        disp_ready_o;
    logic [4:0]  disp_rob_id_i;
    logic [5:0]  disp_prd_i;
    logic [5:0]  disp_prs1_i;
    logic [5:0]  disp_prs2_i;
    logic        disp_rs1_rdy_i;
    logic        disp_rs2_rdy_i;
    logic [63:0] disp_payload_i;
    logic [1:0]  wake_valid_i;
    logic [11:0] wake_tag_i;
    logic        issue_valid_o;
    logic        issue_ready_i;
    logic [4:0]  issue_rob_id_o;
    logic [5:0]  issue_prd_o;
    logic [5:0]  issue_prs1_o;
    logic [5:0]  issue_prs2_o;
    logic [63:0] issue_payload_o;
    logic [3:0]  occupancy_o;

    int n_chk  = 0;
    int n_fail = 0;

    rs_issue_queue #(
        .DEPTH(8), .PHY_WIDTH(6), .ROB_WIDTH(5), .PAYLOAD_W(64), .WAKE_PORTS(2)
    ) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .disp_valid_i(disp_valid_i), .disp_ready_o(disp_ready_o),
        .disp_rob_id_i(disp_rob_id_i), .disp_prd_i(disp_prd_i),
        .disp_prs1_i(disp_prs1_i), .disp_prs2_i(disp_prs2_i),
        .disp_rs1_rdy_i(disp_rs1_rdy_i), .disp_rs2_rdy_i(disp_rs2_rdy_i),
        .disp_payload_i(disp_payload_i),
        .wake_valid_i(wake_valid_i), .wake_tag_i(wake_tag_i),
        .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
        .issue_rob_id_o(issue_rob_id_o), .issue_prd_o(issue_prd_o),
        .issue_prs1_o(issue_prs1_o), .issue_prs2_o(issue_prs2_o),
        .issue_payload_o(issue_payload_o), .occupancy_o(occupancy_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pay_of(input int rob);
        return 64'hA5A5_0000_0000_0000 | 64'(rob);
    endfunction

    task automatic disp(input int rob, input int p1, input int p2, input bit r1, input bit r2);
        disp_valid_i   = 1'b1;
        disp_rob_id_i  = 5'(rob);
        disp_prd_i     = 6'(rob + 40);
        disp_prs1_i    = 6'(p1);
        disp_prs2_i    = 6'(p2);
        disp_rs1_rdy_i = r1;
        disp_rs2_rdy_i = r2;
        disp_payload_i = pay_of(rob);
    endtask

    initial begin
        rst = 1'b0; flush_i = 1'b0; disp_valid_i = 1'b0; issue_ready_i = 1'b0;
        disp_rob_id_i = '0; disp_prd_i = '0; disp_prs1_i = '0; disp_prs2_i = '0;
        disp_rs1_rdy_i = 1'b0; disp_rs2_rdy_i = 1'b0; disp_payload_i = '0;
        wake_valid_i = '0; wake_tag_i = '0;

        // Reset
        tick(); tick();
        chk("rst_issue_valid", 64'(issue_valid_o), 64'd0);
        chk("rst_disp_ready",  64'(disp_ready_o),  64'd1);
        chk("rst_occupancy",   64'(occupancy_o),   64'd0);
        rst = 1'b1;

        // Ready dispatch: tags 0 are implicitly ready
        disp(3, 0, 0, 1'b0, 1'b0);
        tick();
        disp_valid_i = 1'b0;
        #1;
        chk("rd_issue_valid", 64'(issue_valid_o),  64'd1);
        chk("rd_rob",         64'(issue_rob_id_o), 64'd3);
        chk("rd_prd",         64'(issue_prd_o),    64'd43);
        chk("rd_payload",     issue_payload_o,     pay_of(3));
        chk("rd_occ",         64'(occupancy_o),    64'd1);
        issue_ready_i = 1'b1;
        tick();
        issue_ready_i = 1'b0;
        chk("rd_occ_after",   64'(occupancy_o),    64'd0);
        chk("rd_valid_after", 64'(issue_valid_o),  64'd0);

        // Wakeup: older rob 1 waits on tag 12, younger rob 2 ready
        disp(1, 12, 0, 1'b0, 1'b0);
        tick();
        disp(2, 5, 0, 1'b1, 1'b0);
        tick();
        disp_valid_i = 1'b0;
        #1;
        chk("wk_first_rob", 64'(issue_rob_id_o), 64'd2);
        chk("wk_occ2",      64'(occupancy_o),    64'd2);
        issue_ready_i = 1'b1;
        tick();
        issue_ready_i = 1'b0;
        wake_valid_i  = 2'b01;
        wake_tag_i    = {6'd0, 6'd12};
        #1;
        chk("wk_not_yet",   64'(issue_valid_o),  64'd0);
        tick();
        wake_valid_i = 2'b00;
        #1;
        chk("wk_valid",     64'(issue_valid_o),  64'd1);
        chk("wk_rob1",      64'(issue_rob_id_o), 64'd1);
        chk("wk_prs1",      64'(issue_prs1_o),   64'd12);
        issue_ready_i = 1'b1;
        tick();
        issue_ready_i = 1'b0;
        chk("wk_occ0",      64'(occupancy_o),    64'd0);

        // Wake arriving in the same cycle as dispatch, on both ports
        disp(4, 33, 34, 1'b0, 1'b0);
        wake_valid_i = 2'b11;
        wake_tag_i   = {6'd34, 6'd33};
        tick();
        disp_valid_i = 1'b0;
        wake_valid_i = 2'b00;
        #1;
        chk("dw_valid", 64'(issue_valid_o),  64'd1);
        chk("dw_rob",   64'(issue_rob_id_o), 64'd4);
        issue_ready_i = 1'b1;
        tick();
        issue_ready_i = 1'b0;

        // Wake applied to an entry that shifts down in the same cycle
        disp(10, 0, 0, 1'b0, 1'b0);
        tick();
        disp(11, 7, 0, 1'b0, 1'b0);
        tick();
        disp_valid_i  = 1'b0;
        issue_ready_i = 1'b1;
        wake_valid_i  = 2'b10;
        wake_tag_i    = {6'd7, 6'd0};
        #1;
        chk("sw_rob10", 64'(issue_rob_id_o), 64'd10);
        tick();
        issue_ready_i = 1'b0;
        wake_valid_i  = 2'b00;
        #1;
        chk("sw_valid", 64'(issue_valid_o),  64'd1);
        chk("sw_rob11", 64'(issue_rob_id_o), 64'd11);
        issue_ready_i = 1'b1;
        tick();
        issue_ready_i = 1'b0;
        chk("sw_occ0",  64'(occupancy_o),    64'd0);

        // Age order / full: fill rob 0..7, all ready
        for (int i = 0; i < 8; i++) begin
            disp(i, i + 1, i + 2, 1'b1, 1'b1);
            tick();
        end
        disp_valid_i = 1'b0;
        #1;
        chk("full_occ",        64'(occupancy_o),  64'd8);
        chk("full_disp_ready", 64'(disp_ready_o), 64'd0);

        // Full + issue: dispatch is still blocked this cycle
        disp(8, 0, 0, 1'b1, 1'b1);
        issue_ready_i = 1'b1;
        #1;
        chk("fi_disp_ready", 64'(disp_ready_o),   64'd0);
        chk("fi_rob0",       64'(issue_rob_id_o), 64'd0);
        tick();
        chk("fi_occ7",       64'(occupancy_o),    64'd7);

        // Dispatch + issue together: count unchanged
        disp(9, 0, 0, 1'b1, 1'b1);
        #1;
        chk("di_disp_ready", 64'(disp_ready_o),   64'd1);
        chk("di_rob1",       64'(issue_rob_id_o), 64'd1);
        tick();
        disp_valid_i = 1'b0;
        chk("di_occ7",       64'(occupancy_o),    64'd7);

        // Remaining drain order: 2..7 then 9
        for (int i = 2; i < 9; i++) begin
            #1;
            chk("age_valid", 64'(issue_valid_o),  64'd1);
            chk("age_rob",   64'(issue_rob_id_o), (i == 8) ? 64'd9 : 64'(i));
            tick();
        end
        issue_ready_i = 1'b0;
        chk("age_occ0", 64'(occupancy_o), 64'd0);

        // Flush with 5 entries, a dispatch and a wake in flight
        for (int i = 20; i < 25; i++) begin
            disp(i, 0, 0, 1'b1, 1'b1);
            tick();
        end
        disp_valid_i = 1'b0;
        #1;
        chk("fl_occ5",   64'(occupancy_o),   64'd5);
        chk("fl_pre_iv", 64'(issue_valid_o), 64'd1);
        flush_i       = 1'b1;
        issue_ready_i = 1'b1;
        wake_valid_i  = 2'b01;
        wake_tag_i    = {6'd0, 6'd9};
        disp(25, 0, 0, 1'b1, 1'b1);
        #1;
        chk("fl_iv",     64'(issue_valid_o), 64'd0);
        chk("fl_dr",     64'(disp_ready_o),  64'd0);
        tick();
        flush_i       = 1'b0;
        disp_valid_i  = 1'b0;
        issue_ready_i = 1'b0;
        wake_valid_i  = 2'b00;
        #1;
        chk("fl_occ0",   64'(occupancy_o),   64'd0);
        chk("fl_iv0",    64'(issue_valid_o), 64'd0);
        chk("fl_dr1",    64'(disp_ready_o),  64'd1);
        tick();
        chk("fl_occ0b",  64'(occupancy_o),   64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
